// File: rtl/ctrl_arb_pkg.sv
// Shared definitions for the control-source arbiter: FSM encoding and button bit positions.
package ctrl_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OWNED    = 2'd1,
      ST_HANDOVER = 2'd2
   } arb_state_e;

   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;

endpackage

// File: rtl/src_activity_det.sv
// Per-source activity flag: any button pulse, or the set level differing from last cycle.
module src_activity_det #(
   parameter int BTN_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             set_i,
   input  logic [BTN_W-1:0] btn_i,
   output logic             act_o
);

   logic set_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) set_q <= 1'b0;
      else         set_q <= set_i;
   end

   assign act_o = (|btn_i) | (set_i ^ set_q);

endmodule

// File: rtl/ctrl_src_arbiter.sv
// Registered N-way control-source arbiter (manual select / auto ownership with hold timer).
// Build option CTRL_ARB_PREEMPT_EN: local source 0 preempts any other auto-mode owner.
module ctrl_src_arbiter
   import ctrl_arb_pkg::*;
#(
   parameter int NUM_SRC  = 2,
   parameter int MODE_W   = 5,
   parameter int BTN_W    = 4,
   parameter int HOLD_CYC = 100_000_000,
   parameter int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      iClk,
   input  logic                      iRst_n,
   input  logic                      iAuto,
   input  logic [SEL_W-1:0]          iSel,
   input  logic [NUM_SRC-1:0]        iSrc_Set,
   input  logic [NUM_SRC*MODE_W-1:0] iSrc_Mode,
   input  logic [NUM_SRC*BTN_W-1:0]  iSrc_Btn,
   output logic                      oSet,
   output logic [MODE_W-1:0]         oMode,
   output logic [BTN_W-1:0]          oBtn,
   output logic [SEL_W-1:0]          oSel,
   output logic                      oLocked,
   output logic                      oSwitch
);

   localparam int               TMR_W     = (HOLD_CYC > 2) ? $clog2(HOLD_CYC) : 1;
   localparam int               NSLOT     = 1 << SEL_W;
   localparam logic [TMR_W-1:0] RELOAD    = TMR_W'(HOLD_CYC - 1);
   localparam logic [SEL_W:0]   NUM_SRC_L = (SEL_W + 1)'(NUM_SRC);

   // Source views padded to a power of two so the owner index always addresses a real slot.
   logic [NSLOT-1:0]             src_set, src_act;
   logic [NSLOT-1:0][MODE_W-1:0] src_mode;
   logic [NSLOT-1:0][BTN_W-1:0]  src_btn;

   for (genvar k = 0; k < NSLOT; k++) begin : g_src
      if (k < NUM_SRC) begin : g_real
         assign src_set[k]  = iSrc_Set[k];
         assign src_mode[k] = iSrc_Mode[k*MODE_W +: MODE_W];
         assign src_btn[k]  = iSrc_Btn[k*BTN_W +: BTN_W];
         src_activity_det #(.BTN_W(BTN_W)) u_det (
            .clk_i  (iClk),
            .rst_ni (iRst_n),
            .set_i  (iSrc_Set[k]),
            .btn_i  (iSrc_Btn[k*BTN_W +: BTN_W]),
            .act_o  (src_act[k])
         );
      end else begin : g_pad
         assign src_set[k]  = 1'b0;
         assign src_mode[k] = '0;
         assign src_btn[k]  = '0;
         assign src_act[k]  = 1'b0;
      end
   end

   arb_state_e        state_q, state_d;
   logic [SEL_W-1:0]  sel_q, sel_d, cand, ho_tgt;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              set_q, set_d, locked_q, locked_d, switch_q, switch_d;
   logic [MODE_W-1:0] mode_q, mode_d;
   logic [BTN_W-1:0]  btn_q, btn_d;
   logic              auto_q, go_ho, sel_ok, preempt;

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      timer_d  = timer_q;
      set_d    = src_set[sel_q];
      mode_d   = src_mode[sel_q];
      btn_d    = src_btn[sel_q];
      switch_d = 1'b0;
      go_ho    = 1'b0;
      ho_tgt   = sel_q;
      sel_ok   = ({1'b0, iSel} < NUM_SRC_L);
      preempt  = 1'b0;
`ifdef CTRL_ARB_PREEMPT_EN
      preempt  = src_act[0] && (sel_q != '0);
`endif
      cand = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         if (src_act[k]) cand = SEL_W'(k);
      end

      if (!iAuto) begin
         timer_d = '0;
         if (state_q != ST_HANDOVER && sel_ok && iSel != sel_q) begin
            go_ho  = 1'b1;
            ho_tgt = iSel;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (!auto_q) begin
         state_d = ST_OWNED;
         timer_d = RELOAD;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (|src_act) begin
                  if (cand == sel_q) begin
                     state_d = ST_OWNED;
                     timer_d = RELOAD;
                  end else begin
                     go_ho  = 1'b1;
                     ho_tgt = cand;
                  end
               end
            end
            ST_OWNED: begin
               // Owner activity beats expiry; everyone else is dropped unless preempting.
               if (preempt) begin
                  go_ho  = 1'b1;
                  ho_tgt = '0;
               end else if (src_act[sel_q]) begin
                  timer_d = RELOAD;
               end else if (timer_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  timer_d = timer_q - TMR_W'(1);
               end
            end
            ST_HANDOVER: begin
               state_d = ST_OWNED;
               timer_d = RELOAD;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Handover cycle: new index out, buttons muted, level/mode frozen.
      if (go_ho) begin
         state_d  = ST_HANDOVER;
         sel_d    = ho_tgt;
         btn_d    = '0;
         set_d    = set_q;
         mode_d   = mode_q;
         switch_d = 1'b1;
      end
      locked_d = (state_d == ST_OWNED);
   end

   // auto_q resets high so that auto mode at reset release starts in IDLE, not as a 0->1 edge.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         timer_q  <= '0;
         set_q    <= 1'b0;
         mode_q   <= '0;
         btn_q    <= '0;
         locked_q <= 1'b0;
         switch_q <= 1'b0;
         auto_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         timer_q  <= timer_d;
         set_q    <= set_d;
         mode_q   <= mode_d;
         btn_q    <= btn_d;
         locked_q <= locked_d;
         switch_q <= switch_d;
         auto_q   <= iAuto;
      end
   end

   assign oSet    = set_q;
   assign oMode   = mode_q;
   assign oBtn    = btn_q;
   assign oSel    = sel_q;
   assign oLocked = locked_q;
   assign oSwitch = switch_q;

endmodule
